demux_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the 1-to-8 demux (inputs D, SEL; output Y) between eight destination channels. It drives SEL and a gated D for each winning requester. Each grant holds for a fixed dwell period, followed by a one-cycle break-before-make gap. It sits directly in front of the demux; its SEL and D outputs wire straight to the demux inputs.

---
 rtl/demux_pkg.sv | 15 +
 rtl/rr_pick.sv | 35 +++
 rtl/demux_rr_scheduler.sv | 101 ++++++++++
 tb/tb_demux_rr_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the round-robin demux scheduler.
package demux_pkg;

    localparam int N       = 8;
    localparam int SELW    = $clog2(N);
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first asserted request at or after ptr,
// wrapping modulo N. Rotate so ptr sits at bit 0, take the lowest set bit,
// then add ptr back (the SELW-bit add wraps for free since N is a power of two).
module rr_pick
    import demux_pkg::*;
#(
    parameter  int NREQ  = N,
    localparam int PSELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PSELW-1:0] ptr,
    output logic             valid,
    output logic [PSELW-1:0] idx
);

    logic [NREQ-1:0]  rot;
    logic [PSELW-1:0] ofs;

    // rotate requests right by ptr
    for (genvar i = 0; i < NREQ; i++) begin : g_rot
        assign rot[i] = req[PSELW'(i) + ptr];
    end

    // priority-encode the rotated vector, lowest index wins
    always_comb begin
        ofs = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) ofs = PSELW'(i);
        end
    end

    assign valid = |req;
    assign idx   = ofs + ptr;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler in front of a 1-to-N demux: each winner holds the
// demux for DWELL cycles (or until it drops its request), followed by a
// one-cycle gap with D forced low and SEL held so the demux never glitches.
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            EN,
    input  logic [N-1:0]    REQ,
    input  logic            DIN,
    output logic [SELW-1:0] SEL,
    output logic            D,
    output logic [N-1:0]    GNT,
    output logic            BUSY,
    output logic            DONE
);

    state_t               state, state_nxt;
    logic [DWELL_W-1:0]   cnt, cnt_nxt;
    logic [SELW-1:0]      ptr, ptr_nxt;
    logic [SELW-1:0]      sel_nxt;
    logic [N-1:0]         gnt_nxt;
    logic                 pick_vld;
    logic [SELW-1:0]      pick_idx;
    logic                 in_grant;
    logic                 req_held;

    rr_pick #(.NREQ(N)) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign in_grant = (state == GRANT);
    assign req_held = REQ[SEL];

    // state, select, grant, counter and pointer registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            SEL   <= '0;
            GNT   <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            SEL   <= sel_nxt;
            GNT   <= gnt_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // next-state logic; SEL only moves on ARB->GRANT, pointer only on GRANT exit
    always_comb begin
        state_nxt = state;
        sel_nxt   = SEL;
        gnt_nxt   = GNT;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (EN && |REQ) state_nxt = ARB;
            end
            ARB: begin
                if (pick_vld) begin
                    sel_nxt   = pick_idx;
                    gnt_nxt   = N'(1) << pick_idx;
                    cnt_nxt   = DWELL_W'(DWELL - 1);
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                // early release and dwell expiry both end the grant the same way
                if (!req_held || cnt == '0) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = SEL + SELW'(1);
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end
            end
            GAP: begin
                state_nxt = (EN && |REQ) ? ARB : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // data gating and status flags
    assign D    = in_grant & DIN;
    assign BUSY = (state != IDLE);
    assign DONE = in_grant && (cnt == '0) && req_held;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench: two schedulers (DWELL=4 and DWELL=1) share one stimulus
// stream; a reference model pushes the expected per-cycle outputs, including
// the demux Y vector, and a separate monitor pops and compares them.
module tb_demux_rr_scheduler;

    localparam int M_IDLE = 0, M_ARB = 1, M_GRANT = 2, M_GAP = 3;

    logic       clk = 1'b0;
    logic       rst, en, din;
    logic [7:0] req;

    logic [2:0] sel0, sel1;
    logic       d0, d1, busy0, busy1, done0, done1;
    logic [7:0] gnt0, gnt1, y0, y1;

    typedef struct packed {
        logic [2:0] sel;
        logic       d;
        logic [7:0] gnt;
        logic       busy;
        logic       done;
        logic [7:0] y;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_rr_scheduler #(.DWELL(4)) u0 (
        .CLK(clk), .RESET(rst), .EN(en), .REQ(req), .DIN(din),
        .SEL(sel0), .D(d0), .GNT(gnt0), .BUSY(busy0), .DONE(done0)
    );

    demux_rr_scheduler #(.DWELL(1)) u1 (
        .CLK(clk), .RESET(rst), .EN(en), .REQ(req), .DIN(din),
        .SEL(sel1), .D(d1), .GNT(gnt1), .BUSY(busy1), .DONE(done1)
    );

    // behavioural 1-to-8 demux fed by each scheduler
    assign y0 = d0 ? (8'h01 << sel0) : 8'h00;
    assign y1 = d1 ? (8'h01 << sel1) : 8'h00;

    function automatic int first_from(int p, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // reference model: grants counted by age from 0 upward, pointer as an int
    initial begin
        int   mode[2], msel[2], mptr[2], age[2], dw[2];
        bit   primed;
        obs_t e;
        bit   g;
        int   w;
        dw[0] = 4; dw[1] = 1;
        primed = 0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = M_IDLE; msel[i] = 0; mptr[i] = 0; age[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (primed) begin
                    g      = (mode[i] == M_GRANT);
                    e.sel  = 3'(msel[i]);
                    e.gnt  = g ? 8'(1 << msel[i]) : 8'h00;
                    e.d    = g & din;
                    e.busy = (mode[i] != M_IDLE);
                    e.done = g && (age[i] == dw[i] - 1) && req[msel[i]];
                    e.y    = e.d ? e.gnt : 8'h00;
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (rst) begin
                    mode[i] = M_IDLE; msel[i] = 0; mptr[i] = 0; age[i] = 0;
                end else begin
                    case (mode[i])
                        M_IDLE: if (en && req != 8'h00) mode[i] = M_ARB;
                        M_ARB: begin
                            w = first_from(mptr[i], req);
                            if (w >= 0) begin
                                msel[i] = w; age[i] = 0; mode[i] = M_GRANT;
                            end else begin
                                mode[i] = M_IDLE;
                            end
                        end
                        M_GRANT: begin
                            if (!req[msel[i]] || age[i] == dw[i] - 1) begin
                                mptr[i] = (msel[i] + 1) % 8;
                                mode[i] = M_GAP;
                            end else begin
                                age[i]++;
                            end
                        end
                        default: mode[i] = (en && req != 8'h00) ? M_ARB : M_IDLE;
                    endcase
                end
            end
            if (rst) primed = 1;
        end
    end

    // monitor: pop expectations and compare against observed outputs
    initial begin
        obs_t a, x;
        forever begin
            @(negedge clk);
            #1;
            while (q0.size() > 0) begin
                x = q0.pop_front();
                a = '{sel: sel0, d: d0, gnt: gnt0, busy: busy0, done: done0, y: y0};
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL dwell4 t=%0t got sel=%0d d=%b gnt=%h busy=%b done=%b y=%h, expected sel=%0d d=%b gnt=%h busy=%b done=%b y=%h",
                             $time, a.sel, a.d, a.gnt, a.busy, a.done, a.y, x.sel, x.d, x.gnt, x.busy, x.done, x.y);
                end
            end
            while (q1.size() > 0) begin
                x = q1.pop_front();
                a = '{sel: sel1, d: d1, gnt: gnt1, busy: busy1, done: done1, y: y1};
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL dwell1 t=%0t got sel=%0d d=%b gnt=%h busy=%b done=%b y=%h, expected sel=%0d d=%b gnt=%h busy=%b done=%b y=%h",
                             $time, a.sel, a.d, a.gnt, a.busy, a.done, a.y, x.sel, x.d, x.gnt, x.busy, x.done, x.y);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input int ch);
        for (int i = 0; i < 60; i++) begin
            if (gnt0[ch]) begin
                checks++;
                return;
            end
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_gnt ch%0d: no grant within 60 cycles, gnt=%h", ch, gnt0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy0 && !busy1) begin
                checks++;
                return;
            end
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: still busy after 60 cycles, busy=%b%b", busy0, busy1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; req = 8'hFF;
        // reset held with all requests asserted
        cyc(2);
        rst = 1'b0;

        // single requester: grant, gap, re-grant
        en = 1'b1; req = 8'h04; din = 1'b1;
        cyc(14);

        // all requesters: full rotation with wrap, random data
        req = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            din = 1'($urandom);
            cyc();
        end

        // early release of channel 5, then wrap past 6,7 to channel 0
        en = 1'b0; req = 8'h00;
        wait_idle();
        en = 1'b1; req = 8'h20; din = 1'b1;
        wait_gnt(5);
        cyc(2);
        req = 8'h00;
        cyc();
        req = 8'h21;
        cyc(12);

        // enable dropped mid-grant on channel 3
        en = 1'b0; req = 8'h00;
        wait_idle();
        en = 1'b1; req = 8'h08;
        wait_gnt(3);
        cyc();
        en = 1'b0;
        cyc(10);

        // reset in the middle of a grant on channel 6
        en = 1'b1; req = 8'h40;
        wait_gnt(6);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 8'h41;
        cyc(12);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            din = 1'($urandom);
            if ($urandom_range(0, 5) == 0)
                req = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc(3);
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
